// File: rtl/secuenciador_pkg.sv
// Shared definitions for the program-counter sequencer: op encodings and the
// control decode that turns an op plus status into next-pc selection and stack actions.
package secuenciador_pkg;

  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_JMP  = 3'b001,
    OP_JZ   = 3'b010,
    OP_JNZ  = 3'b011,
    OP_CALL = 3'b100,
    OP_RET  = 3'b101,
    OP_HALT = 3'b110
  } op_e;

  typedef enum logic [1:0] {
    SEL_INC  = 2'd0,
    SEL_DEST = 2'd1,
    SEL_HOLD = 2'd2,
    SEL_POP  = 2'd3
  } pc_sel_e;

  typedef struct packed {
    pc_sel_e sel;
    logic    push;
    logic    pop;
    logic    halt;
    logic    ovf;
    logic    unf;
  } ctrl_t;

  // Encoding 3'b111 is unassigned and falls through to the NEXT behaviour.
  function automatic ctrl_t decode_op(input logic [2:0] op, input logic z,
                                      input logic full, input logic empty);
    ctrl_t c;
    c     = '0;
    c.sel = SEL_INC;
    case (op)
      OP_JMP:  c.sel = SEL_DEST;
      OP_JZ:   c.sel = z  ? SEL_DEST : SEL_INC;
      OP_JNZ:  c.sel = !z ? SEL_DEST : SEL_INC;
      OP_CALL: begin
        if (full) begin
          c.sel  = SEL_HOLD;
          c.ovf  = 1'b1;
          c.halt = 1'b1;
        end else begin
          c.sel  = SEL_DEST;
          c.push = 1'b1;
        end
      end
      OP_RET: begin
        if (empty) begin
          c.sel  = SEL_HOLD;
          c.unf  = 1'b1;
          c.halt = 1'b1;
        end else begin
          c.sel  = SEL_POP;
          c.pop  = 1'b1;
        end
      end
      OP_HALT: begin
        c.sel  = SEL_HOLD;
        c.halt = 1'b1;
      end
      default: c.sel = SEL_INC;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pila_lifo.sv
// Return-address stack: LIFO of DEPTH entries with an occupancy count.
// The top entry is presented combinationally on o_data whenever the stack is non-empty.
module pila_lifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     i_push,
  input  logic                     i_pop,
  input  logic [WIDTH-1:0]         i_data,
  output logic [WIDTH-1:0]         o_data,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [CW-1:0]    r_count;
  logic [AW-1:0]    w_wr_idx;
  logic [AW-1:0]    w_rd_idx;
  logic             w_full;
  logic             w_empty;

  assign w_full   = (r_count == CW'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign w_wr_idx = r_count[AW-1:0];
  // With a full stack the low bits wrap to 0, so minus one still lands on DEPTH-1.
  assign w_rd_idx = r_count[AW-1:0] - AW'(1);

  // NOTE: storage has no reset; only the count is cleared, so stale entries are unreachable.
  always_ff @(posedge clk) begin
    if (i_push && !w_full) begin
      r_mem[w_wr_idx] <= i_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_count <= '0;
    end else if (i_push && !w_full) begin
      r_count <= r_count + CW'(1);
    end else if (i_pop && !w_empty) begin
      r_count <= r_count - CW'(1);
    end
  end

  assign o_data  = r_mem[w_rd_idx];
  assign o_count = r_count;

endmodule

// File: rtl/secuenciador_pc.sv
// Program-counter sequencer: next-pc multiplexer, pc register, sticky halt/error
// flags and a call/return stack for nested subroutines.
module secuenciador_pc
  import secuenciador_pkg::*;
#(
  parameter int PC_WIDTH    = 10,
  parameter int STACK_DEPTH = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en,
  input  logic [2:0]                   op,
  input  logic [PC_WIDTH-1:0]          dest,
  input  logic                         z,
  output logic [PC_WIDTH-1:0]          pc,
  output logic [$clog2(STACK_DEPTH):0] nivel,
  output logic                         fin,
  output logic                         err_ovf,
  output logic                         err_unf
);

  localparam int LW = $clog2(STACK_DEPTH) + 1;

  logic [PC_WIDTH-1:0] r_pc;
  logic                r_fin;
  logic                r_ovf;
  logic                r_unf;

  logic [PC_WIDTH-1:0] w_pc_inc;
  logic [PC_WIDTH-1:0] w_pc_next;
  logic [PC_WIDTH-1:0] w_stack_top;
  logic [LW-1:0]       w_count;
  logic                w_full;
  logic                w_empty;
  logic                w_act;
  ctrl_t               w_ctrl;

  // Once halted, only reset can bring the sequencer back.
  assign w_act    = en & ~r_fin & ~reset;
  assign w_full   = (w_count == LW'(STACK_DEPTH));
  assign w_empty  = (w_count == '0);
  assign w_ctrl   = decode_op(op, z, w_full, w_empty);
  assign w_pc_inc = r_pc + PC_WIDTH'(1);

  // NOTE: default assigned before the case so no path leaves w_pc_next unassigned (no latch).
  always_comb begin
    w_pc_next = w_pc_inc;
    case (w_ctrl.sel)
      SEL_DEST: w_pc_next = dest;
      SEL_HOLD: w_pc_next = r_pc;
      SEL_POP:  w_pc_next = w_stack_top;
      default:  w_pc_next = w_pc_inc;
    endcase
  end

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_pc  <= '0;
      r_fin <= 1'b0;
      r_ovf <= 1'b0;
      r_unf <= 1'b0;
    end else if (w_act) begin
      r_pc <= w_pc_next;
      if (w_ctrl.halt) r_fin <= 1'b1;
      if (w_ctrl.ovf)  r_ovf <= 1'b1;
      if (w_ctrl.unf)  r_unf <= 1'b1;
    end
  end

  pila_lifo #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_pila (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_act & w_ctrl.push),
    .i_pop   (w_act & w_ctrl.pop),
    .i_data  (w_pc_inc),
    .o_data  (w_stack_top),
    .o_count (w_count)
  );

  assign pc      = r_pc;
  assign nivel   = w_count;
  assign fin     = r_fin;
  assign err_ovf = r_ovf;
  assign err_unf = r_unf;

endmodule

// File: tb/tb_secuenciador_pc.sv
// Bench for secuenciador_pc: a reference model feeds a scoreboard queue checked one
// cycle after each drive, plus directed scenarios with fixed expected values.
module tb_secuenciador_pc;
  import secuenciador_pkg::*;

  localparam int PW = 10;
  localparam int SD = 8;
  localparam int LW = 4;

  typedef struct packed {
    logic [PW-1:0] pc;
    logic [LW-1:0] nivel;
    logic          fin;
    logic          ovf;
    logic          unf;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, en, z;
  logic [2:0]    op;
  logic [PW-1:0] dest;
  logic [PW-1:0] pc;
  logic [LW-1:0] nivel;
  logic          fin, err_ovf, err_unf;

  logic          reset4, en4, z4;
  logic [2:0]    op4;
  logic [3:0]    dest4;
  logic [3:0]    pc4;
  logic [LW-1:0] nivel4;
  logic          fin4, ovf4, unf4;

  secuenciador_pc #(.PC_WIDTH(PW), .STACK_DEPTH(SD)) u_dut (
    .clk(clk), .reset(reset), .en(en), .op(op), .dest(dest), .z(z),
    .pc(pc), .nivel(nivel), .fin(fin), .err_ovf(err_ovf), .err_unf(err_unf)
  );

  secuenciador_pc #(.PC_WIDTH(4), .STACK_DEPTH(SD)) u_dut4 (
    .clk(clk), .reset(reset4), .en(en4), .op(op4), .dest(dest4), .z(z4),
    .pc(pc4), .nivel(nivel4), .fin(fin4), .err_ovf(ovf4), .err_unf(unf4)
  );

  // Reference model state
  logic [PW-1:0] m_pc;
  logic [PW-1:0] m_stack [$];
  logic          m_fin, m_ovf, m_unf;

  exp_t sb_q [$];
  exp_t sb_exp;
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_steps  = 0;

  task automatic model_step(input logic i_rst, input logic i_en, input logic [2:0] i_op,
                            input logic [PW-1:0] i_dest, input logic i_z);
    if (i_rst) begin
      m_pc = '0;
      m_stack.delete();
      m_fin = 1'b0;
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else if (i_en && !m_fin) begin
      case (i_op)
        OP_JMP: m_pc = i_dest;
        OP_JZ:  m_pc = i_z ? i_dest : m_pc + PW'(1);
        OP_JNZ: m_pc = i_z ? m_pc + PW'(1) : i_dest;
        OP_CALL: begin
          if (m_stack.size() == SD) begin
            m_ovf = 1'b1;
            m_fin = 1'b1;
          end else begin
            m_stack.push_back(m_pc + PW'(1));
            m_pc = i_dest;
          end
        end
        OP_RET: begin
          if (m_stack.size() == 0) begin
            m_unf = 1'b1;
            m_fin = 1'b1;
          end else begin
            m_pc = m_stack.pop_back();
          end
        end
        OP_HALT: m_fin = 1'b1;
        default: m_pc = m_pc + PW'(1);
      endcase
    end
  endtask

  // One cycle on the main DUT; returns 2 time units after the edge.
  task automatic drive(input logic i_rst, input logic i_en, input logic [2:0] i_op,
                       input logic [PW-1:0] i_dest, input logic i_z);
    exp_t e;
    @(negedge clk);
    reset = i_rst;
    en    = i_en;
    op    = i_op;
    dest  = i_dest;
    z     = i_z;
    model_step(i_rst, i_en, i_op, i_dest, i_z);
    e.pc    = m_pc;
    e.nivel = LW'(m_stack.size());
    e.fin   = m_fin;
    e.ovf   = m_ovf;
    e.unf   = m_unf;
    sb_q.push_back(e);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard: compares the expectation queued for the edge just taken.
  always @(posedge clk) begin
    #1;
    if (sb_q.size() != 0) begin
      sb_exp = sb_q.pop_front();
      n_steps++;
      n_checks++;
      if (pc !== sb_exp.pc) begin
        n_errors++;
        $display("FAIL sb_pc step %0d: got %0d expected %0d", n_steps, pc, sb_exp.pc);
      end
      n_checks++;
      if (nivel !== sb_exp.nivel) begin
        n_errors++;
        $display("FAIL sb_nivel step %0d: got %0d expected %0d", n_steps, nivel, sb_exp.nivel);
      end
      n_checks++;
      if ({fin, err_ovf, err_unf} !== {sb_exp.fin, sb_exp.ovf, sb_exp.unf}) begin
        n_errors++;
        $display("FAIL sb_flags step %0d: got fin/ovf/unf=%b%b%b expected %b%b%b", n_steps,
                 fin, err_ovf, err_unf, sb_exp.fin, sb_exp.ovf, sb_exp.unf);
      end
    end
  end

  task automatic test_reset();
    drive(1'b1, 1'b1, OP_CALL, 10'd55, 1'b0);
    n_checks++;
    if ({pc, nivel, fin, err_ovf, err_unf} !== {10'd0, 4'd0, 3'b000}) begin
      n_errors++;
      $display("FAIL reset_state: got pc=%0d nivel=%0d flags=%b%b%b expected all zero",
               pc, nivel, fin, err_ovf, err_unf);
    end
  endtask

  task automatic test_next();
    for (int i = 1; i <= 4; i++) begin
      drive(1'b0, 1'b1, OP_NEXT, 10'd0, 1'b0);
      n_checks++;
      if (pc !== PW'(i)) begin
        n_errors++;
        $display("FAIL next_seq: got pc=%0d expected %0d", pc, i);
      end
    end
  endtask

  task automatic test_branch();
    drive(1'b0, 1'b1, OP_JMP, 10'd5, 1'b0);
    drive(1'b0, 1'b1, OP_JZ, 10'd20, 1'b0);
    n_checks++;
    if (pc !== 10'd6) begin
      n_errors++;
      $display("FAIL jz_not_taken: got pc=%0d expected 6", pc);
    end
    drive(1'b0, 1'b1, OP_JZ, 10'd20, 1'b1);
    n_checks++;
    if (pc !== 10'd20) begin
      n_errors++;
      $display("FAIL jz_taken: got pc=%0d expected 20", pc);
    end
    drive(1'b0, 1'b1, OP_JNZ, 10'd3, 1'b1);
    n_checks++;
    if (pc !== 10'd21) begin
      n_errors++;
      $display("FAIL jnz_not_taken: got pc=%0d expected 21", pc);
    end
    drive(1'b0, 1'b1, OP_JNZ, 10'd3, 1'b0);
    n_checks++;
    if (pc !== 10'd3) begin
      n_errors++;
      $display("FAIL jnz_taken: got pc=%0d expected 3", pc);
    end
    drive(1'b0, 1'b1, 3'b111, 10'd99, 1'b1);
    n_checks++;
    if (pc !== 10'd4) begin
      n_errors++;
      $display("FAIL op111_next: got pc=%0d expected 4", pc);
    end
  endtask

  task automatic test_call_ret();
    logic [PW-1:0] exp_pc [4];
    logic [LW-1:0] exp_nv [4];
    exp_pc = '{10'd100, 10'd200, 10'd101, 10'd11};
    exp_nv = '{4'd1, 4'd2, 4'd1, 4'd0};
    drive(1'b0, 1'b1, OP_JMP, 10'd10, 1'b0);
    drive(1'b0, 1'b1, OP_CALL, 10'd100, 1'b0);
    for (int i = 0; i < 4; i++) begin
      if (i == 1) drive(1'b0, 1'b1, OP_CALL, 10'd200, 1'b0);
      if (i >= 2) drive(1'b0, 1'b1, OP_RET, 10'd0, 1'b0);
      n_checks++;
      if ({pc, nivel} !== {exp_pc[i], exp_nv[i]}) begin
        n_errors++;
        $display("FAIL call_ret[%0d]: got pc=%0d nivel=%0d expected pc=%0d nivel=%0d",
                 i, pc, nivel, exp_pc[i], exp_nv[i]);
      end
    end
  endtask

  task automatic test_overflow();
    drive(1'b1, 1'b0, OP_NEXT, 10'd0, 1'b0);
    for (int i = 1; i <= SD; i++) drive(1'b0, 1'b1, OP_CALL, PW'(i * 10), 1'b0);
    n_checks++;
    if (nivel !== 4'd8 || fin !== 1'b0) begin
      n_errors++;
      $display("FAIL ovf_fill: got nivel=%0d fin=%b expected nivel=8 fin=0", nivel, fin);
    end
    drive(1'b0, 1'b1, OP_CALL, 10'd999, 1'b0);
    n_checks++;
    if ({pc, nivel, fin, err_ovf, err_unf} !== {10'd80, 4'd8, 3'b110}) begin
      n_errors++;
      $display("FAIL ovf_ninth: got pc=%0d nivel=%0d flags=%b%b%b expected pc=80 nivel=8 flags=110",
               pc, nivel, fin, err_ovf, err_unf);
    end
    repeat (3) drive(1'b0, 1'b1, OP_NEXT, 10'd0, 1'b0);
    n_checks++;
    if (pc !== 10'd80) begin
      n_errors++;
      $display("FAIL ovf_ignore: got pc=%0d expected 80", pc);
    end
    drive(1'b1, 1'b1, OP_RET, 10'd0, 1'b0);
    n_checks++;
    if ({pc, nivel, fin, err_ovf, err_unf} !== {10'd0, 4'd0, 3'b000}) begin
      n_errors++;
      $display("FAIL ovf_reset: got pc=%0d nivel=%0d flags=%b%b%b expected all zero",
               pc, nivel, fin, err_ovf, err_unf);
    end
  endtask

  task automatic test_underflow();
    drive(1'b1, 1'b0, OP_NEXT, 10'd0, 1'b0);
    drive(1'b0, 1'b1, OP_RET, 10'd0, 1'b0);
    n_checks++;
    if ({pc, fin, err_ovf, err_unf} !== {10'd0, 3'b101}) begin
      n_errors++;
      $display("FAIL unf_ret: got pc=%0d flags=%b%b%b expected pc=0 flags=101",
               pc, fin, err_ovf, err_unf);
    end
    drive(1'b1, 1'b0, OP_NEXT, 10'd0, 1'b0);
  endtask

  task automatic drive4(input logic i_rst, input logic i_en, input logic [2:0] i_op,
                        input logic [3:0] i_dest);
    @(negedge clk);
    reset  = 1'b0;
    en     = 1'b0;
    reset4 = i_rst;
    en4    = i_en;
    op4    = i_op;
    dest4  = i_dest;
    z4     = 1'b0;
    @(posedge clk);
    #2;
  endtask

  task automatic test_wrap();
    drive(1'b0, 1'b1, OP_JMP, 10'd1023, 1'b0);
    drive(1'b0, 1'b1, OP_NEXT, 10'd0, 1'b0);
    n_checks++;
    if ({pc, fin, err_ovf, err_unf} !== {10'd0, 3'b000}) begin
      n_errors++;
      $display("FAIL wrap10: got pc=%0d flags=%b%b%b expected pc=0 flags=000",
               pc, fin, err_ovf, err_unf);
    end
    drive4(1'b1, 1'b0, OP_NEXT, 4'd0);
    drive4(1'b0, 1'b1, OP_JMP, 4'd15);
    n_checks++;
    if (pc4 !== 4'd15) begin
      n_errors++;
      $display("FAIL wrap4_jmp: got pc=%0d expected 15", pc4);
    end
    drive4(1'b0, 1'b1, OP_NEXT, 4'd0);
    n_checks++;
    if ({pc4, nivel4, fin4, ovf4, unf4} !== {4'd0, 4'd0, 3'b000}) begin
      n_errors++;
      $display("FAIL wrap4_next: got pc=%0d nivel=%0d flags=%b%b%b expected pc=0 nivel=0 flags=000",
               pc4, nivel4, fin4, ovf4, unf4);
    end
    drive4(1'b0, 1'b0, OP_NEXT, 4'd0);
  endtask

  task automatic test_halt();
    drive(1'b1, 1'b0, OP_NEXT, 10'd0, 1'b0);
    drive(1'b0, 1'b1, OP_JMP, 10'd7, 1'b0);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, (i == 0) ? OP_CALL : OP_NEXT, 10'd300, 1'b0);
      n_checks++;
      if ({pc, nivel} !== {10'd7, 4'd0}) begin
        n_errors++;
        $display("FAIL en_low_hold[%0d]: got pc=%0d nivel=%0d expected pc=7 nivel=0", i, pc, nivel);
      end
    end
    drive(1'b0, 1'b1, OP_HALT, 10'd0, 1'b0);
    n_checks++;
    if ({pc, fin} !== {10'd7, 1'b1}) begin
      n_errors++;
      $display("FAIL halt: got pc=%0d fin=%b expected pc=7 fin=1", pc, fin);
    end
    repeat (10) drive(1'b0, 1'b1, OP_NEXT, 10'd0, 1'b0);
    n_checks++;
    if ({pc, fin} !== {10'd7, 1'b1}) begin
      n_errors++;
      $display("FAIL halt_hold: got pc=%0d fin=%b expected pc=7 fin=1", pc, fin);
    end
    drive(1'b1, 1'b1, OP_JMP, 10'd44, 1'b0);
    n_checks++;
    if ({pc, fin} !== {10'd0, 1'b0}) begin
      n_errors++;
      $display("FAIL halt_reset: got pc=%0d fin=%b expected pc=0 fin=0", pc, fin);
    end
  endtask

  task automatic test_back_to_back();
    logic [2:0] r_op;
    drive(1'b1, 1'b0, OP_NEXT, 10'd0, 1'b0);
    for (int i = 0; i < 400; i++) begin
      if (m_fin && $urandom_range(0, 3) == 0) begin
        drive(1'b1, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 10'($urandom), 1'b0);
      end else begin
        r_op = 3'($urandom_range(0, 7));
        if (r_op == OP_HALT && $urandom_range(0, 2) != 0) r_op = OP_CALL;
        drive(1'b0, ($urandom_range(0, 4) != 0), r_op, 10'($urandom), 1'($urandom_range(0, 1)));
      end
    end
  endtask

  initial begin
    reset  = 1'b0; en  = 1'b0; op  = OP_NEXT; dest  = '0; z  = 1'b0;
    reset4 = 1'b0; en4 = 1'b0; op4 = OP_NEXT; dest4 = '0; z4 = 1'b0;
    test_reset();
    test_next();
    test_branch();
    test_call_ret();
    test_overflow();
    test_underflow();
    test_wrap();
    test_halt();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish within time limit");
    $fatal(1);
  end

endmodule

// File: doc/secuenciador_pc.md
SECUENCIADOR_PC -- requirements
Module: secuenciador_pc

Interface
REQ-001 The module SHALL have parameter PC_WIDTH, default 10, program-counter width in bits.
REQ-002 The module SHALL have parameter STACK_DEPTH, default 8, maximum nested subroutine calls (power of two, ≥2).
REQ-003 The module SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-004 The module SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 The module SHALL have port en, input, 1, advance enable; sequencer acts only when high.
REQ-006 The module SHALL have port op, input, 3, sequencing operation code.
REQ-007 The module SHALL have port dest, input, PC_WIDTH, jump/call target address.
REQ-008 The module SHALL have port z, input, 1, zero flag from the datapath.
REQ-009 The module SHALL have port pc, output, PC_WIDTH, current instruction address (registered).
REQ-010 The module SHALL have port nivel, output, clog2(STACK_DEPTH)+1, current stack occupancy (registered).
REQ-011 The module SHALL have port fin, output, 1, halted flag (registered, sticky).
REQ-012 The module SHALL have port err_ovf, output, 1, call-stack overflow flag (registered, sticky).
REQ-013 The module SHALL have port err_unf, output, 1, return-stack underflow flag (registered, sticky).

Function
REQ-014 With en=1 and fin=0, the operation SHALL take effect on the same rising edge; new pc is visible one cycle after op is presented.
REQ-015 op=000 NEXT SHALL load pc+1; op=111 SHALL behave as NEXT.
REQ-016 op=001 JMP SHALL load dest.
REQ-017 op=010 JZ SHALL load dest if z=1, else pc+1.
REQ-018 op=011 JNZ SHALL load dest if z=0, else pc+1.
REQ-019 op=100 CALL SHALL push pc+1, increment nivel, and load dest.
REQ-020 op=101 RET SHALL pop the top entry into pc and decrement nivel.
REQ-021 op=110 HALT SHALL set fin and hold pc.
REQ-022 pc+1 SHALL wrap modulo 2^PC_WIDTH (all-ones -> 0) without flagging an error.
REQ-023 CALL with nivel=STACK_DEPTH SHALL not push, SHALL set err_ovf and fin, and SHALL hold pc and nivel.
REQ-024 RET with nivel=0 SHALL set err_unf and fin, and SHALL hold pc.
REQ-025 With en=0, pc, nivel, stack and flags SHALL hold.
REQ-026 With fin=1, all ops and en SHALL be ignored until reset.
REQ-027 The stack SHALL be LIFO; a RET SHALL return the most recent unreturned CALL's pc+1.

Reset
REQ-028 Reset SHALL force pc=0, nivel=0, fin=0, err_ovf=0, err_unf=0 on the next rising edge.
REQ-029 Reset SHALL take priority over en and op, including during a halted or error state.
REQ-030 Stack storage contents SHALL NOT be cleared by reset; they are undefined until pushed.

Structure
REQ-031 The op encodings (NEXT, JMP, JZ, JNZ, CALL, RET, HALT) SHALL be named constants in a shared package, secuenciador_pkg, also used by the control unit.
REQ-032 The stack SHALL be a separate sub-module, pila_lifo (parameters WIDTH, DEPTH; push, pop, data in/out, count).
REQ-033 The pc register and next-pc multiplexer SHALL reside in secuenciador_pc.

Verification
REQ-034 Reset, then 4 cycles of NEXT -> pc sequence 0,1,2,3,4; nivel=0; all flags 0.
REQ-035 pc=5, JZ dest=20 with z=0 -> pc=6; then JZ dest=20 with z=1 -> pc=20; then JNZ dest=3 with z=1 -> pc=21.
REQ-036 At pc=10, CALL dest=100, then at pc=100 CALL dest=200, then RET, RET -> pc 100, 200, 101, 11; nivel 1, 2, 1, 0.
REQ-037 STACK_DEPTH=8: 8 CALLs succeed (nivel=8); 9th CALL -> err_ovf=1, fin=1, pc unchanged; further NEXT ignored; reset -> pc=0, flags 0.
REQ-038 After reset, RET -> err_unf=1, fin=1, pc=0; PC_WIDTH=4, JMP dest=15, NEXT -> pc=0, no error.
REQ-039 HALT at pc=7 -> fin=1, pc holds 7 for 10 cycles of NEXT; en=0 for 3 cycles before the HALT -> pc holds.
